// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: prefetch port, CPU port and RAM port.
// master = environment side (requesters + RAM), slave = the arbiter.
interface fb_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 24
);
    logic              pf_req;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_gnt;
    logic              pf_rvalid;
    logic [DATA_W-1:0] pf_rdata;
    logic              pf_done;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output pf_req, pf_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  pf_gnt, pf_rvalid, pf_rdata, pf_done,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  pf_req, pf_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output pf_gnt, pf_rvalid, pf_rdata, pf_done,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display prefetch bursts have priority,
// a starvation counter forces a CPU slot once the CPU has waited STARVE_MAX cycles.
module fb_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 24,
    parameter int BURST      = 16,
    parameter int STARVE_MAX = 64
) (
    input logic         clk,
    input logic         rst,
    fb_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_CPU   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              pf_gnt_q, pf_gnt_d;
    logic              pf_rvalid_q, pf_rvalid_d;
    logic              pf_done_q, pf_done_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              starved;
    logic              take_cpu;

    assign starved  = (starve_q == SW'(STARVE_MAX));
    assign take_cpu = bus.cpu_req && (starved || !bus.pf_req);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        pf_gnt_d    = 1'b0;
        cpu_gnt_d   = 1'b0;
        // Read data returns the cycle after each issue, so valids trail the issuing state.
        pf_rvalid_d  = (state_q == S_BURST);
        pf_done_d    = (state_q == S_BURST) && (cnt_q == CNT_W'(BURST));
        cpu_rvalid_d = (state_q == S_CPU) && !ram_we_q;

        case (state_q)
            S_IDLE: begin
                if (take_cpu) begin
                    state_d     = S_CPU;
                    ram_en_d    = 1'b1;
                    ram_we_d    = bus.cpu_we;
                    ram_addr_d  = bus.cpu_addr;
                    ram_wdata_d = bus.cpu_wdata;
                    cpu_gnt_d   = 1'b1;
                end else if (bus.pf_req) begin
                    state_d    = S_BURST;
                    ram_en_d   = 1'b1;
                    ram_addr_d = bus.pf_addr;
                    pf_gnt_d   = 1'b1;
                    cnt_d      = CNT_W'(1);
                end
            end
            S_BURST: begin
                if (cnt_q == CNT_W'(BURST)) begin
                    state_d = S_IDLE;
                end else begin
                    // ram_addr_q holds the latched base plus offset; wraps modulo 2^ADDR_W.
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            S_CPU:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.cpu_req || cpu_gnt_q)
            starve_d = '0;
        else if (!starved)
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            cnt_q        <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            pf_gnt_q     <= 1'b0;
            pf_rvalid_q  <= 1'b0;
            pf_done_q    <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            cnt_q        <= cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            pf_gnt_q     <= pf_gnt_d;
            pf_rvalid_q  <= pf_rvalid_d;
            pf_done_q    <= pf_done_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    // RAM output register supplies the data; gating keeps rdata at 0 outside valid cycles.
    assign bus.pf_rdata   = pf_rvalid_q  ? bus.ram_rdata : '0;
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.ram_rdata : '0;
    assign bus.pf_gnt     = pf_gnt_q;
    assign bus.pf_rvalid  = pf_rvalid_q;
    assign bus.pf_done    = pf_done_q;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: RAM model preloaded with an address-derived pattern.
module tb_fb_arbiter;
    localparam int AW = 20;
    localparam int DW = 24;
    localparam int BL = 16;
    localparam int SM = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BL), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    logic [DW-1:0] pf_exp[$];
    logic [DW-1:0] cpu_exp[$];

    logic [DW-1:0] mem [0:16383];
    bit   [16383:0] wr_seen;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[13:0], 10'h2A5};
    endfunction

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr[13:0]]     <= bus.ram_wdata;
                wr_seen[bus.ram_addr[13:0]] <= 1'b1;
            end else begin
                bus.ram_rdata <= wr_seen[bus.ram_addr[13:0]] ? mem[bus.ram_addr[13:0]]
                                                             : init_word(bus.ram_addr);
            end
        end
    end

    wire [98:0] all_out = {bus.pf_gnt, bus.pf_rvalid, bus.pf_rdata, bus.pf_done,
                           bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata,
                           bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};

    task automatic test_reset();
        rst = 1'b0;
        bus.pf_req = 1'b0; bus.pf_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        n_run++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if (bus.ram_en !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_access: ram_en got %b want 0", bus.ram_en);
        end
    endtask

    task automatic test_burst(input logic [AW-1:0] base);
        int k, nv, gcyc;
        logic [DW-1:0] e;
        @(negedge clk);
        bus.pf_req = 1'b1; bus.pf_addr = base;
        for (int i = 0; i < BL; i++) pf_exp.push_back(init_word(AW'(base + AW'(i))));
        k = 0; nv = 0; gcyc = -1;
        for (int c = 1; c <= BL + 6; c++) begin
            @(negedge clk);
            if (bus.pf_gnt) begin
                gcyc = c; bus.pf_req = 1'b0;
            end
            if (bus.ram_en) begin
                n_run++;
                if (bus.ram_we !== 1'b0 || bus.ram_addr !== AW'(base + AW'(k)) || c != k + 1) begin
                    n_fail++;
                    $display("FAIL burst_addr: cycle %0d got we=%b addr=%h want we=0 addr=%h at cycle %0d",
                             c, bus.ram_we, bus.ram_addr, AW'(base + AW'(k)), k + 1);
                end
                k++;
            end
            if (bus.pf_rvalid) begin
                nv++;
                e = (pf_exp.size() > 0) ? pf_exp.pop_front() : 'x;
                n_run++;
                if (bus.pf_rdata !== e) begin
                    n_fail++; $display("FAIL burst_data: beat %0d got %h want %h", nv, bus.pf_rdata, e);
                end
                n_run++;
                if (bus.pf_done !== (nv == BL)) begin
                    n_fail++; $display("FAIL burst_done: beat %0d got %b want %b", nv, bus.pf_done, nv == BL);
                end
            end else if (bus.pf_done) begin
                n_run++; n_fail++; $display("FAIL burst_done: got stray done at cycle %0d want none", c);
            end
        end
        n_run++;
        if (gcyc != 1) begin
            n_fail++; $display("FAIL burst_gnt: got cycle %0d want 1", gcyc);
        end
        n_run++;
        if (k != BL || nv != BL) begin
            n_fail++; $display("FAIL burst_len: got issues=%0d beats=%0d want %0d", k, nv, BL);
        end
    endtask

    task automatic test_cpu();
        int gc, rc;
        logic [DW-1:0] e;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 20'h02000; bus.cpu_wdata = 24'hABCDEF;
        gc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                gc = c; bus.cpu_req = 1'b0;
                n_run++;
                if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {2'b11, 20'h02000, 24'hABCDEF}) begin
                    n_fail++;
                    $display("FAIL cpu_write_issue: got en=%b we=%b addr=%h wd=%h want 1 1 02000 abcdef",
                             bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
                end
            end
            if (bus.cpu_rvalid) begin
                n_run++; n_fail++; $display("FAIL cpu_write_rvalid: got rvalid at cycle %0d want none", c);
            end
        end
        n_run++;
        if (gc != 1) begin
            n_fail++; $display("FAIL cpu_write_gnt: got cycle %0d want 1", gc);
        end

        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
        cpu_exp.push_back(24'hABCDEF);
        gc = -1; rc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                gc = c; bus.cpu_req = 1'b0;
            end
            if (bus.cpu_rvalid) begin
                rc = c;
                e = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 'x;
                n_run++;
                if (bus.cpu_rdata !== e) begin
                    n_fail++; $display("FAIL cpu_read_data: got %h want %h", bus.cpu_rdata, e);
                end
            end
        end
        n_run++;
        if (gc != 1 || rc != 2) begin
            n_fail++; $display("FAIL cpu_read_timing: got gnt=%0d rvalid=%0d want 1 2", gc, rc);
        end
    endtask

    task automatic test_contention();
        int pg, cg, nv;
        logic [DW-1:0] e;
        @(negedge clk);
        bus.pf_req = 1'b1; bus.pf_addr = 20'h00500;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00100;
        for (int i = 0; i < BL; i++) pf_exp.push_back(init_word(AW'(20'h00500 + i)));
        cpu_exp.push_back(init_word(20'h00100));
        pg = -1; cg = -1; nv = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.pf_gnt)  begin pg = c; bus.pf_req = 1'b0; end
            if (bus.cpu_gnt) begin cg = c; bus.cpu_req = 1'b0; end
            if (bus.pf_rvalid) begin
                nv++;
                e = (pf_exp.size() > 0) ? pf_exp.pop_front() : 'x;
                n_run++;
                if (bus.pf_rdata !== e) begin
                    n_fail++; $display("FAIL contend_pf_data: beat %0d got %h want %h", nv, bus.pf_rdata, e);
                end
            end
            if (bus.cpu_rvalid) begin
                e = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 'x;
                n_run++;
                if (bus.cpu_rdata !== e) begin
                    n_fail++; $display("FAIL contend_cpu_data: got %h want %h", bus.cpu_rdata, e);
                end
            end
        end
        n_run++;
        if (pg != 1 || cg != BL + 2) begin
            n_fail++; $display("FAIL contend_order: got pf_gnt=%0d cpu_gnt=%0d want 1 %0d", pg, cg, BL + 2);
        end
    endtask

    task automatic test_starve();
        int cg, npf;
        logic [DW-1:0] e;
        @(negedge clk);
        bus.pf_req = 1'b1; bus.pf_addr = 20'h00800;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00900;
        cpu_exp.push_back(init_word(20'h00900));
        cg = -1; npf = 0;
        for (int c = 1; c <= 120 && cg < 0; c++) begin
            @(negedge clk);
            if (bus.pf_gnt) npf++;
            if (bus.cpu_gnt) begin cg = c; bus.cpu_req = 1'b0; end
        end
        n_run++;
        if (cg < 0 || cg > SM + BL + 1) begin
            n_fail++; $display("FAIL starve_bound: got cpu_gnt cycle %0d want 1..%0d", cg, SM + BL + 1);
        end
        n_run++;
        if (npf != 4) begin
            n_fail++; $display("FAIL starve_bursts: got %0d bursts before cpu want 4", npf);
        end
        @(negedge clk);
        bus.pf_req = 1'b0;
        n_run++;
        if (dut.starve_q !== '0) begin
            n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.starve_q);
        end
        e = (cpu_exp.size() > 0) ? cpu_exp.pop_front() : 'x;
        n_run++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e) begin
            n_fail++; $display("FAIL starve_read: got rvalid=%b data=%h want 1 %h", bus.cpu_rvalid, bus.cpu_rdata, e);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        bus.pf_req = 1'b1; bus.pf_addr = 20'h00300;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.pf_gnt) bus.pf_req = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        n_run++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h want 0", all_out);
        end
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.pf_rvalid || bus.pf_done) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midreset_abandon: got %0d rvalid/done cycles want 0", bad);
        end
        test_burst(20'h00400);
    endtask

    initial begin
        test_reset();
        test_burst(20'h00100);
        test_cpu();
        test_contention();
        test_starve();
        test_burst(20'hFFFF8);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
